// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   state_e      - control FSM states
//   req_cls_e    - request classification (legal / illegal funct3 / misaligned)
//   F3_*         - RISC-V load/store funct3 encodings
//   lsu_classify - classifies a request from we, funct3 and the low address bits
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    CLS_LEGAL,
    CLS_ILLEGAL,
    CLS_MISALIGN
  } req_cls_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal funct3 takes priority; alignment is only judged for legal sizes.
  function automatic req_cls_e lsu_classify(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    req_cls_e cls;
    cls = CLS_LEGAL;
    if (we) begin
      if (!(funct3 inside {F3_B, F3_H, F3_W})) cls = CLS_ILLEGAL;
    end else begin
      if (!(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) cls = CLS_ILLEGAL;
    end
    if (cls == CLS_LEGAL) begin
      case (funct3)
        F3_H, F3_HU: if (addr_lo[0])       cls = CLS_MISALIGN;
        F3_W:        if (addr_lo != 2'b00) cls = CLS_MISALIGN;
        default: ;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3  in  : access size / signedness
//   addr_lo in  : byte offset within the word
//   rdata   in  : word read from memory
//   wdata   in  : store data (low byte/halfword used for SB/SH)
//   ld_data out : selected lane, sign- or zero-extended (W passes through)
//   st_word out : rdata with the store lane replaced (W: wdata as-is)
// Lanes are little-endian; halfword selection uses addr_lo[1] only.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: ;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = rdata;
    endcase

    st_word = rdata;
    case (funct3[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0: st_word[7:0]   = wdata[7:0];
          2'd1: st_word[15:8]  = wdata[7:0];
          2'd2: st_word[23:16] = wdata[7:0];
          2'd3: st_word[31:24] = wdata[7:0];
          default: ;
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) st_word[31:16] = wdata[15:0];
        else            st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit in front of a word-wide memory
// (async read, sync word write). One request at a time; SB/SH are done as
// read-modify-write.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata : request fields, latched on accept
//   resp_valid/rdata/err  : one-cycle completion pulse with extended load data
//   mem_addr/write_en/wdata, mem_rdata : word memory port
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned H/HU/W
// requests complete with resp_err and make no access; otherwise the low
// address bits below the access size are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;   // load result, or merged word for RMW
  logic              err_q, err_d;

  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] st_merged;
  req_cls_e          cls;
  logic              req_err;
  logic              accept;
  logic              sw_access;

  lsu_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_ext),
    .st_word (st_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cls = lsu_classify(req_we, req_funct3, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = (cls != CLS_LEGAL);
`else
    req_err = (cls == CLS_ILLEGAL);
`endif
    accept  = req_valid && (state_q == ST_IDLE);
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = '0;
          err_d   = req_err;
          state_d = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          data_d  = ld_ext;
          state_d = ST_RESP;
        end else if (f3_q == F3_W) begin
          state_d = ST_RESP;
        end else begin
          data_d  = st_merged;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sw_access    = (state_q == ST_ACCESS) && we_q && (f3_q == F3_W);
    req_ready    = (state_q == ST_IDLE);
    resp_valid   = (state_q == ST_RESP);
    resp_err     = (state_q == ST_RESP) && err_q;
    resp_rdata   = ((state_q == ST_RESP) && !we_q && !err_q) ? data_q : '0;
    mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    mem_write_en = sw_access || (state_q == ST_WRITE);
    mem_wdata    = '0;
    if (sw_access)                 mem_wdata = wdata_q;
    else if (state_q == ST_WRITE)  mem_wdata = data_q;
  end

endmodule
